// File: rtl/pattern_det_pkg.sv
// Shared types, parameter defaults and helpers for the programmable pattern detector.
package pattern_det_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CONFIGURED = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam int DEF_MAXLEN = 8;
  localparam int DEF_LW     = 4;
  localparam int DEF_CW     = 8;
  localparam int DEF_SW     = 16;

  // A pattern length is usable only if it is at least one bit and fits the shift register.
  function automatic logic len_legal(input int len, input int maxlen);
    return (len >= 1) && (len <= maxlen);
  endfunction

endpackage

// File: rtl/pattern_shift_match.sv
// Serial shift register with fill-history tracking and a length-masked pattern compare.
// hit looks at the contents the register will hold after the current sample is shifted in.
module pattern_shift_match
  import pattern_det_pkg::*;
#(
  parameter int MAXLEN = DEF_MAXLEN,
  parameter int LW     = DEF_LW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              x,
  input  logic [LW-1:0]     len,
  input  logic [MAXLEN-1:0] pattern,
  input  logic              overlap,
  output logic              hit
);

  logic [MAXLEN-1:0] sr;
  logic [MAXLEN-1:0] sr_next;
  logic [MAXLEN-1:0] mask;
  logic [LW-1:0]     hist;
  logic [LW-1:0]     hist_next;

  // Next register contents, saturating history and the compare against the low len bits.
  always_comb begin
    sr_next   = {sr[MAXLEN-2:0], x};
    hist_next = (hist >= LW'(MAXLEN)) ? LW'(MAXLEN) : hist + LW'(1);
    mask      = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
    end
    hit = (hist_next >= len) && (((sr_next ^ pattern) & mask) == '0);
  end

  // Shift on each valid sample; without overlap a match empties the history so the
  // next detection needs a completely fresh set of len bits.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      sr   <= '0;
      hist <= '0;
    end else if (shift_en) begin
      sr   <= sr_next;
      hist <= (hit && !overlap) ? '0 : hist_next;
    end
  end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Configurable serial pattern-detector controller: config handshake, run sequencing,
// match counting and completion on match target or sample limit.
module pattern_det_ctrl
  import pattern_det_pkg::*;
#(
  parameter int MAXLEN = DEF_MAXLEN,
  parameter int LW     = DEF_LW,
  parameter int CW     = DEF_CW,
  parameter int SW     = DEF_SW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  input  logic [CW-1:0]     cfg_target,
  input  logic [SW-1:0]     cfg_limit,
  input  logic              start,
  input  logic              abort,
  input  logic              x,
  input  logic              x_valid,
  output logic              match,
  output logic [CW-1:0]     match_cnt,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  state_t            state;
  state_t            state_n;
  logic [MAXLEN-1:0] pat_q;
  logic [LW-1:0]     len_q;
  logic              ovl_q;
  logic [CW-1:0]     target_q;
  logic [SW-1:0]     limit_q;
  logic [SW-1:0]     samples;
  logic [CW-1:0]     cnt_q;
  logic              match_q;
  logic              timeout_q;

  logic              hit;
  logic              cfg_accept;
  logic              run_enter;
  logic              sample;
  logic [CW-1:0]     cnt_next;
  logic [SW-1:0]     samples_next;
  logic              target_hit;
  logic              limit_hit;

  // Qualified events and next counter values for the current cycle.
  always_comb begin
    cfg_accept   = (state == IDLE) && cfg_valid && len_legal(int'(cfg_len), MAXLEN);
    run_enter    = (state == CONFIGURED) && start && !abort;
    sample       = (state == RUN) && x_valid && !abort;
    cnt_next     = cnt_q;
    if (hit && (cnt_q != '1)) cnt_next = cnt_q + CW'(1);
    samples_next = samples + SW'(1);
    target_hit   = sample && hit && (target_q != '0) && (cnt_next == target_q);
    limit_hit    = sample && (limit_q != '0) && (samples_next == limit_q);
  end

  // Next-state decode and state-derived outputs; abort overrides everything else.
  always_comb begin
    state_n   = state;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_accept) state_n = CONFIGURED;
      end
      CONFIGURED: if (start) state_n = RUN;
      RUN: begin
        busy = 1'b1;
        if (target_hit || limit_hit) state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_n = CONFIGURED;
      end
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Latch the configuration when a legal one is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      target_q <= '0;
      limit_q  <= '0;
    end else if (cfg_accept) begin
      pat_q    <= cfg_pattern;
      len_q    <= cfg_len;
      ovl_q    <= cfg_overlap;
      target_q <= cfg_target;
      limit_q  <= cfg_limit;
    end
  end

  // Run counters, registered match pulse and timeout flag; a sample that both matches
  // and exhausts the limit still counts the match and is not reported as a timeout
  // when that match reaches the target.
  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      cnt_q     <= '0;
      samples   <= '0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      match_q <= sample && hit;
      if (run_enter) begin
        cnt_q     <= '0;
        samples   <= '0;
        timeout_q <= 1'b0;
      end else if (sample) begin
        cnt_q   <= cnt_next;
        samples <= samples_next;
        if (target_hit || limit_hit) timeout_q <= limit_hit && !target_hit;
      end
    end
  end

  pattern_shift_match #(
    .MAXLEN(MAXLEN),
    .LW    (LW)
  ) u_shift_match (
    .clk     (clk),
    .rst     (rst),
    .clr     (run_enter || abort),
    .shift_en(sample),
    .x       (x),
    .len     (len_q),
    .pattern (pat_q),
    .overlap (ovl_q),
    .hit     (hit)
  );

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed bench for pattern_det_ctrl with hand-computed expectations.
module tb_pattern_det_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [7:0]  cfg_target;
  logic [15:0] cfg_limit;
  logic        start;
  logic        abort;
  logic        x;
  logic        x_valid;
  logic        match;
  logic [7:0]  match_cnt;
  logic        busy;
  logic        done;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  logic [7:0] stream1;
  logic [7:0] expOvl;
  logic [7:0] expNoOvl;
  logic [5:0] expTgt;

  pattern_det_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .cfg_limit  (cfg_limit),
    .start      (start),
    .abort      (abort),
    .x          (x),
    .x_valid    (x_valid),
    .match      (match),
    .match_cnt  (match_cnt),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One sample cycle (or a gap cycle when xv=0).
  task automatic applyStimulus(input logic xv, input logic xb);
    x       = xb;
    x_valid = xv;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input logic [7:0] tgt, input logic [15:0] lim);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_target  = tgt;
    cfg_limit   = lim;
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulseAbort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    stream1  = 8'b0110_1101;
    expOvl   = 8'b0000_1001;
    expNoOvl = 8'b0000_1000;
    expTgt   = 6'b001110;
    rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; cfg_limit = '0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;

    // Reset values
    tick(); tick();
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 1);
    checkOutput("rst_match", 32'(match), 0);
    checkOutput("rst_cnt", 32'(match_cnt), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_timeout", 32'(timeout), 0);
    rst = 1'b1;

    // Start ignored in IDLE, zero length rejected
    pulseStart();
    checkOutput("idle_start_busy", 32'(busy), 0);
    checkOutput("idle_start_ready", 32'(cfg_ready), 1);
    configure(8'b0000_1101, 4'd0, 1'b1, 8'd0, 16'd8);
    checkOutput("len0_ready", 32'(cfg_ready), 1);
    configure(8'b0000_1101, 4'd9, 1'b1, 8'd0, 16'd8);
    checkOutput("len9_ready", 32'(cfg_ready), 1);

    // Basic overlap run
    configure(8'b0000_1101, 4'd5, 1'b1, 8'd0, 16'd8);
    checkOutput("cfg_ready_low", 32'(cfg_ready), 0);
    checkOutput("cfg_busy_low", 32'(busy), 0);
    pulseStart();
    checkOutput("run_busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, stream1[7-i]);
      checkOutput($sformatf("ovl_match%0d", i + 1), 32'(match), 32'(expOvl[7-i]));
      checkOutput($sformatf("ovl_done%0d", i + 1), 32'(done), (i == 7) ? 1 : 0);
    end
    checkOutput("ovl_cnt", 32'(match_cnt), 2);
    checkOutput("ovl_timeout", 32'(timeout), 1);
    checkOutput("ovl_busy", 32'(busy), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("done_no_match", 32'(match), 0);
    checkOutput("done_cnt_hold", 32'(match_cnt), 2);

    // Re-run with gaps between samples
    pulseStart();
    checkOutput("rerun_cfgd_done", 32'(done), 0);
    checkOutput("rerun_cfgd_cnt", 32'(match_cnt), 2);
    pulseStart();
    checkOutput("gap_busy", 32'(busy), 1);
    checkOutput("gap_cnt_clr", 32'(match_cnt), 0);
    checkOutput("gap_timeout_clr", 32'(timeout), 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, stream1[7-i]);
      checkOutput($sformatf("gap_match%0d", i + 1), 32'(match), 32'(expOvl[7-i]));
      if (i < 7) begin
        applyStimulus(1'b0, ~stream1[7-i]);
        checkOutput($sformatf("gap_idle_a%0d", i + 1), 32'(match), 0);
        applyStimulus(1'b0, ~stream1[7-i]);
        checkOutput($sformatf("gap_idle_b%0d", i + 1), 32'(match), 0);
      end
    end
    checkOutput("gap_cnt", 32'(match_cnt), 2);
    checkOutput("gap_done", 32'(done), 1);
    checkOutput("gap_timeout", 32'(timeout), 1);

    // Abort from DONE, then non-overlap run
    pulseAbort();
    checkOutput("abort_done_ready", 32'(cfg_ready), 1);
    checkOutput("abort_done_cnt", 32'(match_cnt), 0);
    checkOutput("abort_done_done", 32'(done), 0);
    configure(8'b0000_1101, 4'd5, 1'b0, 8'd0, 16'd8);
    pulseStart();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, stream1[7-i]);
      checkOutput($sformatf("novl_match%0d", i + 1), 32'(match), 32'(expNoOvl[7-i]));
    end
    checkOutput("novl_cnt", 32'(match_cnt), 1);
    checkOutput("novl_done", 32'(done), 1);
    checkOutput("novl_timeout", 32'(timeout), 1);

    // Target stop on 111 with six ones
    pulseAbort();
    configure(8'b0000_0111, 4'd3, 1'b1, 8'd3, 16'd0);
    pulseStart();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput($sformatf("tgt_match%0d", i + 1), 32'(match), 32'(expTgt[5-i]));
      checkOutput($sformatf("tgt_done%0d", i + 1), 32'(done), (i >= 4) ? 1 : 0);
    end
    checkOutput("tgt_cnt", 32'(match_cnt), 3);
    checkOutput("tgt_timeout", 32'(timeout), 0);

    // Abort mid-run
    pulseAbort();
    configure(8'b0000_0111, 4'd3, 1'b1, 8'd0, 16'd0);
    pulseStart();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("pre_abort_cnt", 32'(match_cnt), 1);
    pulseAbort();
    checkOutput("abort_ready", 32'(cfg_ready), 1);
    checkOutput("abort_cnt", 32'(match_cnt), 0);
    checkOutput("abort_busy", 32'(busy), 0);

    // Reset mid-run
    configure(8'b0000_0111, 4'd3, 1'b1, 8'd0, 16'd0);
    pulseStart();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("pre_rst_cnt", 32'(match_cnt), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("mrst_ready", 32'(cfg_ready), 1);
    checkOutput("mrst_cnt", 32'(match_cnt), 0);
    checkOutput("mrst_busy", 32'(busy), 0);
    checkOutput("mrst_match", 32'(match), 0);
    checkOutput("mrst_done", 32'(done), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mrst_no_pulse", 32'(match), 0);

    // Abort beats start in CONFIGURED
    configure(8'b0000_0111, 4'd3, 1'b1, 8'd0, 16'd0);
    checkOutput("cfgd_ready", 32'(cfg_ready), 0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort_start_ready", 32'(cfg_ready), 1);
    checkOutput("abort_start_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
